// File: rtl/ro_pair_meas_sched_pkg.sv
// Shared types and default timing for the RO-pair PUF measurement scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ro_puf_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        SETUP_A   = 4'd1,
        SETTLE_A  = 4'd2,
        COUNT_A   = 4'd3,
        GUARD_A   = 4'd4,
        CAPTURE_A = 4'd5,
        SETUP_B   = 4'd6,
        SETTLE_B  = 4'd7,
        COUNT_B   = 4'd8,
        GUARD_B   = 4'd9,
        CAPTURE_B = 4'd10,
        COMPARE   = 4'd11,
        DONE      = 4'd12
    } state_t;

    localparam int unsigned SETTLE_CYC_DEF = 32'd2000000000;
    localparam int unsigned WINDOW_CYC_DEF = 32'd500000;
    localparam int unsigned GUARD_CYC_DEF  = 32'd4;

    // RO must keep running from settle through the guard so the counter sees a clean tail.
    function automatic logic ro_active(input state_t s);
        return (s == SETTLE_A) || (s == COUNT_A) || (s == GUARD_A) ||
               (s == SETTLE_B) || (s == COUNT_B) || (s == GUARD_B);
    endfunction

    function automatic logic counting(input state_t s);
        return (s == COUNT_A) || (s == COUNT_B);
    endfunction

endpackage

// File: rtl/ro_pair_meas_sched_if.sv
// Bundle between the scheduler, the challenge source and the RO bank/counter.
// Latency: n/a (wires only).
// Backpressure: none; start is a pulse, abort a level.
interface ro_pair_meas_sched_if #(
    parameter int SEL_W = 4,
    parameter int CNT_W = 32
);
    logic             start;
    logic             abort;
    logic [SEL_W-1:0] chal_a;
    logic [SEL_W-1:0] chal_b;
    logic [SEL_W-1:0] ro_sel;
    logic             ro_en;
    logic             cnt_clr;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_val;
    logic [CNT_W-1:0] count_a;
    logic [CNT_W-1:0] count_b;
    logic             resp;
    logic             tie;
    logic             resp_valid;
    logic             busy;

    modport master (
        input  start, abort, chal_a, chal_b, cnt_val,
        output ro_sel, ro_en, cnt_clr, cnt_en, count_a, count_b,
               resp, tie, resp_valid, busy
    );

    modport slave (
        output start, abort, chal_a, chal_b, cnt_val,
        input  ro_sel, ro_en, cnt_clr, cnt_en, count_a, count_b,
               resp, tie, resp_valid, busy
    );
endinterface

// File: rtl/ro_pair_meas_sched_phase_timer.sv
// Down-counting phase timer: load N-1 on phase entry, expired while it reads 0.
// Latency: load visible the cycle after it is asserted.
// Backpressure: none; clr wins over load.
module phase_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             clr,
    output logic             expired
);

    logic [CNT_W-1:0] timer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (clr) begin
            timer <= '0;
        end else if (load) begin
            timer <= load_val;
        end else if (timer != '0) begin
            timer <= timer - 1'b1;
        end
    end

    assign expired = (timer == '0);

endmodule

// File: rtl/ro_pair_meas_sched.sv
// Sequences one RO-pair measurement (A then B) and emits the comparison bit.
// Latency: 2*(SETTLE_CYC+WINDOW_CYC+GUARD_CYC+2)+2 cycles from accepted start to resp_valid.
// Backpressure: none; start ignored while busy, abort returns to IDLE next edge.
module ro_pair_meas_sched
    import ro_puf_pkg::*;
#(
    parameter int          SEL_W      = 4,
    parameter int          CNT_W      = 32,
    parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int unsigned WINDOW_CYC = WINDOW_CYC_DEF,
    parameter int unsigned GUARD_CYC  = GUARD_CYC_DEF
) (
    input logic                 clk,
    input logic                 rst_n,
    ro_pair_meas_sched_if.master bus
);

    if (SETTLE_CYC == 0 || (64'(SETTLE_CYC) >> CNT_W) != 64'd0) begin : g_bad_settle
        $error("SETTLE_CYC must be >= 1 and fit in CNT_W bits");
    end
    if (WINDOW_CYC == 0 || (64'(WINDOW_CYC) >> CNT_W) != 64'd0) begin : g_bad_window
        $error("WINDOW_CYC must be >= 1 and fit in CNT_W bits");
    end
    if (GUARD_CYC == 0 || (64'(GUARD_CYC) >> CNT_W) != 64'd0) begin : g_bad_guard
        $error("GUARD_CYC must be >= 1 and fit in CNT_W bits");
    end

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] chal_a_q;
    logic [SEL_W-1:0] chal_b_q;
    logic             tmr_load;
    logic             tmr_clr;
    logic             tmr_expired;
    logic [CNT_W-1:0] tmr_load_val;

    always_comb begin
        state_nxt = state;
        if (bus.abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:      if (bus.start) state_nxt = SETUP_A;
                SETUP_A:   state_nxt = SETTLE_A;
                SETTLE_A:  if (tmr_expired) state_nxt = COUNT_A;
                COUNT_A:   if (tmr_expired) state_nxt = GUARD_A;
                GUARD_A:   if (tmr_expired) state_nxt = CAPTURE_A;
                CAPTURE_A: state_nxt = SETUP_B;
                SETUP_B:   state_nxt = SETTLE_B;
                SETTLE_B:  if (tmr_expired) state_nxt = COUNT_B;
                COUNT_B:   if (tmr_expired) state_nxt = GUARD_B;
                GUARD_B:   if (tmr_expired) state_nxt = CAPTURE_B;
                CAPTURE_B: state_nxt = COMPARE;
                COMPARE:   state_nxt = DONE;
                DONE:      state_nxt = IDLE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    // Timed phases never re-enter themselves, so a state change is the phase-entry strobe.
    always_comb begin
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        if (state_nxt != state) begin
            case (state_nxt)
                SETTLE_A, SETTLE_B: begin
                    tmr_load     = 1'b1;
                    tmr_load_val = CNT_W'(SETTLE_CYC - 32'd1);
                end
                COUNT_A, COUNT_B: begin
                    tmr_load     = 1'b1;
                    tmr_load_val = CNT_W'(WINDOW_CYC - 32'd1);
                end
                GUARD_A, GUARD_B: begin
                    tmr_load     = 1'b1;
                    tmr_load_val = CNT_W'(GUARD_CYC - 32'd1);
                end
                default: ;
            endcase
        end
    end

    assign tmr_clr = (state_nxt == IDLE);

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .clr      (tmr_clr),
        .expired  (tmr_expired)
    );

    // Outputs are decoded from the next state so they switch on the edge the state is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            chal_a_q       <= '0;
            chal_b_q       <= '0;
            bus.ro_sel     <= '0;
            bus.ro_en      <= 1'b0;
            bus.cnt_clr    <= 1'b0;
            bus.cnt_en     <= 1'b0;
            bus.count_a    <= '0;
            bus.count_b    <= '0;
            bus.resp       <= 1'b0;
            bus.tie        <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            state          <= state_nxt;
            bus.ro_en      <= ro_active(state_nxt);
            bus.cnt_en     <= counting(state_nxt);
            bus.cnt_clr    <= (state_nxt == SETUP_A) || (state_nxt == SETUP_B);
            bus.resp_valid <= (state_nxt == DONE);
            bus.busy       <= (state_nxt != IDLE);

            if (state == IDLE && state_nxt == SETUP_A) begin
                chal_a_q   <= bus.chal_a;
                chal_b_q   <= bus.chal_b;
                bus.ro_sel <= bus.chal_a;
            end else if (state == CAPTURE_A && state_nxt == SETUP_B) begin
                bus.ro_sel <= chal_b_q;
            end

            if (state == CAPTURE_A && state_nxt == SETUP_B) begin
                bus.count_a <= bus.cnt_val;
            end
            if (state == CAPTURE_B && state_nxt == COMPARE) begin
                bus.count_b <= bus.cnt_val;
            end
            if (state == COMPARE && state_nxt == DONE) begin
                bus.resp <= (bus.count_a > bus.count_b);
                bus.tie  <= (bus.count_a == bus.count_b);
            end
        end
    end

endmodule
